// File: rtl/logicnet_pkg.sv
// Shared definitions for the MNIST LogicNet output stages.
package logicnet_pkg;

  localparam int unsigned N_CLASSES_MNIST = 10;
  localparam int unsigned CLASS_W         = $clog2(N_CLASSES_MNIST);

  typedef enum logic [1:0] {
    ACCUM,
    SCAN,
    HOLD
  } ens_argmax_state_t;

endpackage

// File: rtl/ens_argmax_scan.sv
// Sequential argmax comparator: one candidate per cycle, strict greater-than,
// so ties keep the lowest index seen first.
module ens_argmax_scan #(
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned ACC_W     = 4,
  parameter int unsigned CLASS_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               en,
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [CLASS_W-1:0] idx,
  output logic               done,
  output logic [CLASS_W-1:0] best_class,
  output logic [ACC_W-1:0]   best_score
);

  logic [CLASS_W-1:0] best_class_q, best_class_d;
  logic [ACC_W-1:0]   best_score_q, best_score_d;

  // Next best: start resets to class 0 / score 0 (any acc[0] >= 0 then keeps
  // class 0 unless beaten), otherwise take the candidate only if strictly larger.
  always_comb begin
    best_class_d = best_class_q;
    best_score_d = best_score_q;
    if (start) begin
      best_class_d = '0;
      best_score_d = '0;
    end else if (en && (acc_i > best_score_q)) begin
      best_class_d = idx;
      best_score_d = acc_i;
    end
  end

  // Best-so-far registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_class_q <= '0;
      best_score_q <= '0;
    end else begin
      best_class_q <= best_class_d;
      best_score_q <= best_score_d;
    end
  end

  // Outputs include the current comparison so the caller can capture the
  // final result on the same edge as the last candidate.
  assign best_class = best_class_d;
  assign best_score = best_score_d;
  assign done       = en && (idx == CLASS_W'(N_CLASSES - 1));

endmodule

// File: rtl/ens_argmax_accum.sv
// Ensemble output stage: sums per-class logits over N_ENS beats, then scans
// the sums for the winning class and holds it on a valid/ready output.
module ens_argmax_accum #(
  parameter  int unsigned N_ENS     = 4,
  parameter  int unsigned N_CLASSES = 10,
  parameter  int unsigned LOGIT_W   = 2,
  localparam int unsigned ACC_W     = LOGIT_W + $clog2(N_ENS),
  localparam int unsigned CLASS_W   = $clog2(N_CLASSES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_CLASSES*LOGIT_W-1:0] in_logits,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CLASS_W-1:0]           out_class,
  output logic [ACC_W-1:0]             out_score
);

  import logicnet_pkg::*;

  localparam int unsigned CNT_W = (N_ENS > 1) ? $clog2(N_ENS) : 1;

  ens_argmax_state_t                    state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [CLASS_W-1:0]                   scan_idx_q, scan_idx_d;
  logic [N_CLASSES-1:0][ACC_W-1:0]      acc_q, acc_d;
  logic [CLASS_W-1:0]                   out_class_q, out_class_d;
  logic [ACC_W-1:0]                     out_score_q, out_score_d;

  logic               scan_start;
  logic               scan_en;
  logic               scan_done;
  logic [CLASS_W-1:0] scan_best_class;
  logic [ACC_W-1:0]   scan_best_score;

  ens_argmax_scan #(
    .N_CLASSES (N_CLASSES),
    .ACC_W     (ACC_W),
    .CLASS_W   (CLASS_W)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .start      (scan_start),
    .en         (scan_en),
    .acc_i      (acc_q[scan_idx_q]),
    .idx        (scan_idx_q),
    .done       (scan_done),
    .best_class (scan_best_class),
    .best_score (scan_best_score)
  );

  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == HOLD) && !rst;
  assign out_class = out_class_q;
  assign out_score = out_score_q;

  // Next-state, accumulation and scan control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scan_idx_d  = scan_idx_q;
    acc_d       = acc_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    scan_start  = 1'b0;
    scan_en     = 1'b0;
    case (state_q)
      ACCUM: begin
        if (in_valid && in_ready) begin
          // First beat of an image loads instead of adding, which discards
          // the previous image's sums without a clear cycle.
          for (int unsigned c = 0; c < N_CLASSES; c++) begin
            acc_d[c] = ((cnt_q == '0) ? '0 : acc_q[c])
                       + ACC_W'(in_logits[c*LOGIT_W +: LOGIT_W]);
          end
          if (cnt_q == CNT_W'(N_ENS - 1)) begin
            cnt_d      = '0;
            scan_idx_d = '0;
            scan_start = 1'b1;
            state_d    = SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (scan_done) begin
          out_class_d = scan_best_class;
          out_score_d = scan_best_score;
          state_d     = HOLD;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      scan_idx_q  <= '0;
      acc_q       <= '0;
      out_class_q <= '0;
      out_score_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scan_idx_q  <= scan_idx_d;
      acc_q       <= acc_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
    end
  end

endmodule

// File: tb/tb_ens_argmax_accum.sv
// Bench for ens_argmax_accum: vector table plus hand sequences, results
// checked by a scoreboard on each output handshake.
module tb_ens_argmax_accum;

  localparam int NE = 4;
  localparam int NC = 10;
  localparam int LW = 2;
  localparam int AW = 4;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [NC*LW-1:0] in_logits;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_class;
  logic [AW-1:0]    out_score;

  ens_argmax_accum #(
    .N_ENS     (NE),
    .N_CLASSES (NC),
    .LOGIT_W   (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_logits (in_logits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [CW-1:0] cls;
    logic [AW-1:0] score;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [NC*LW-1:0] beat [NE];
    int               cls;
    int               score;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [NC*LW-1:0] setc(input logic [NC*LW-1:0] v, input int c, input int val);
    logic [NC*LW-1:0] r;
    r = v;
    r[c*LW +: LW] = LW'(val);
    return r;
  endfunction

  task automatic push_exp(input int c, input int s);
    exp_t e;
    e.cls   = CW'(c);
    e.score = AW'(s);
    sb.push_back(e);
  endtask

  // Scoreboard: compare whenever a handshake will happen on the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: class %0d score %0d with nothing expected", out_class, out_score);
      end else begin
        e = sb.pop_front();
        check("out_class", int'(out_class), int'(e.cls));
        check("out_score", int'(out_score), int'(e.score));
      end
    end
  end

  // Returns at #1 after the edge that accepted the beat.
  task automatic send_beat(input logic [NC*LW-1:0] l);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_logits = l;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_beat: in_ready stuck low (got 0 required 1)");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d results outstanding (required 0)", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t2 [4];
    int t7 [4];
    int pat [7];
    int bi, k, t, c0, s0;
    bit ok;
    int sums [NC];
    int bc, bs;
    logic [NC*LW-1:0] rv [NE];

    t2  = '{3, 3, 0, 0};
    t7  = '{0, 1, 2, 3};
    pat = '{1, 0, 0, 1, 0, 1, 1};

    for (int b = 0; b < NE; b++) begin
      tbl[0].beat[b] = setc('0, 3, 3);
      tbl[1].beat[b] = setc(setc(setc('0, 2, t2[b]), 7, t7[b]), 0, 1);
      tbl[2].beat[b] = '0;
      tbl[3].beat[b] = '1;
      tbl[4].beat[b] = setc(setc('0, 9, 3), 8, 2);
      tbl[5].beat[b] = '0;
      for (int c = 0; c < NC; c++) tbl[5].beat[b] = setc(tbl[5].beat[b], c, (c * b) % 4);
    end
    tbl[0].cls = 3; tbl[0].score = 12;
    tbl[1].cls = 2; tbl[1].score = 6;
    tbl[2].cls = 0; tbl[2].score = 0;
    tbl[3].cls = 0; tbl[3].score = 12;
    tbl[4].cls = 9; tbl[4].score = 12;
    tbl[5].cls = 1; tbl[5].score = 6;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_logits = '0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);
    check("post_rst_class", int'(out_class), 0);
    check("post_rst_score", int'(out_score), 0);
    @(posedge clk);
    #1;

    // Table vectors, gap-free
    for (int i = 0; i < 6; i++) begin
      push_exp(tbl[i].cls, tbl[i].score);
      for (int b = 0; b < NE; b++) send_beat(tbl[i].beat[b]);
      wait_drain();
    end

    // Latency: out_valid rises after edge k+10, in_ready low while scanning
    push_exp(3, 12);
    for (int b = 0; b < NE; b++) send_beat(tbl[0].beat[b]);
    k  = cyc;
    ok = 1'b1;
    t  = 0;
    @(negedge clk);
    while (!out_valid && t < 40) begin
      if (in_ready) ok = 1'b0;
      @(negedge clk);
      t++;
    end
    check("latency", cyc - k, NC);
    check("in_ready_low_in_scan", int'(ok), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("in_ready_after_hs", int'(in_ready), 1);
    check("out_valid_after_hs", int'(out_valid), 0);
    check("class_kept_after_hs", int'(out_class), 3);
    @(posedge clk);
    #1;

    // Back-pressure on the output
    out_ready = 1'b0;
    push_exp(2, 6);
    for (int b = 0; b < NE; b++) send_beat(tbl[1].beat[b]);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    c0 = int'(out_class);
    s0 = int'(out_score);
    ok = out_valid;
    repeat (5) begin
      @(negedge clk);
      if (int'(out_class) != c0 || int'(out_score) != s0 || in_ready || !out_valid) ok = 1'b0;
    end
    check("bp_stable", int'(ok), 1);
    check("bp_class", c0, 2);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();
    push_exp(9, 4);
    for (int b = 0; b < NE; b++) send_beat(setc('0, 9, 1));
    wait_drain();

    // Reset mid-image drops the partial sums
    send_beat(setc('0, 5, 3));
    send_beat(setc('0, 5, 3));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_class_cleared", int'(out_class), 0);
    check("midrst_score_cleared", int'(out_score), 0);
    @(posedge clk);
    #1;
    push_exp(1, 8);
    for (int b = 0; b < NE; b++) send_beat(setc('0, 1, 2));
    wait_drain();

    // Input bubbles; idle cycles carry junk that must be ignored
    push_exp(2, 6);
    bi = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i][0];
      if (pat[i] != 0) begin
        in_logits = tbl[1].beat[bi];
        bi++;
      end else begin
        in_logits = '1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();

    // Random images against a reference argmax
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < NC; c++) sums[c] = 0;
      for (int b = 0; b < NE; b++) begin
        rv[b] = NC*LW'($urandom);
        for (int c = 0; c < NC; c++) sums[c] += int'(rv[b][c*LW +: LW]);
      end
      bc = 0;
      bs = sums[0];
      for (int c = 1; c < NC; c++) begin
        if (sums[c] > bs) begin
          bc = c;
          bs = sums[c];
        end
      end
      push_exp(bc, bs);
      for (int b = 0; b < NE; b++) send_beat(rv[b]);
      wait_drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ens_argmax_accum.md
# ens_argmax_accum

Output stage that sits directly downstream of the final LUT layer of each ensemble member in the MNIST LogicNet. It accepts one member's class-logit vector per handshake beat and sums the logits per class across `N_ENS` members. It then scans the sums sequentially to find the winning class and presents the class index and its score on a valid/ready output.

## Interface
Parameters:
- `N_ENS`, 4, number of ensemble members (beats) per image; ≥1
- `N_CLASSES`, 10, number of classes; ≥2
- `LOGIT_W`, 2, width of one unsigned per-class logit from the final layer
- derived, not overridable: `ACC_W` = `LOGIT_W` + clog2(`N_ENS`); `CLASS_W` = clog2(`N_CLASSES`)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  logit vector valid
- `in_ready`  out  1  block can accept a vector
- `in_logits`  in  `N_CLASSES*LOGIT_W`  class c at bits [c*LOGIT_W +: LOGIT_W], unsigned
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_class`  out  `CLASS_W`  winning class index
- `out_score`  out  `ACC_W`  summed score of the winning class

## Operation
- FSM states: ACCUM, SCAN, HOLD. Reset enters ACCUM.
- ACCUM:
  - `in_ready`=1. Each accepted beat (`in_valid`&&`in_ready`) updates every class accumulator and increments the member counter.
  - Member counter = 0: the beat loads `acc[c]` = logit. There is no separate clear cycle, so leftovers from the previous image are discarded.
  - Otherwise: `acc[c]` += logit. `ACC_W` guarantees no overflow.
  - Beat with counter = `N_ENS`-1: counter returns to 0, scan index is set to 0, best is set to class 0, and the FSM goes to SCAN.
  - Cycles with `in_valid`=0 change nothing.
- SCAN:
  - `in_ready`=0. One class per cycle, index i = 0..`N_CLASSES`-1.
  - Best is replaced only if `acc[i]` > best score (strict). Ties therefore resolve to the lowest index.
  - After i = `N_CLASSES`-1, register `out_class`/`out_score` and go to HOLD.
- HOLD:
  - `out_valid`=1 and `in_ready`=0. Outputs are stable while `out_ready`=0.
  - Handshake (`out_valid`&&`out_ready`) returns to ACCUM.
  - `out_class`/`out_score` keep their values after the handshake until the next result overwrites them.
- Reset, at any point including mid-accumulation or mid-scan:
  - State = ACCUM; member counter, scan index, and accumulators = 0.
  - `out_valid`=0, `out_class`=0, `out_score`=0.
  - `in_ready`=0 while `rst` is asserted.
  - Partial images are dropped.

## Timing
- `in_ready` and `out_valid` are decoded combinationally from the registered state, with no input-to-output combinational path.
- Final input beat accepted at edge k:
  - SCAN occupies cycles k..k+`N_CLASSES`-1.
  - `out_valid` rises after edge k+`N_CLASSES`.
- Minimum period per image: `N_ENS` + `N_CLASSES` + 1 cycles, achieved with `in_valid` and `out_ready` held high.
- `in_ready` first goes high in the cycle after the HOLD handshake edge.
- Output back-pressure stalls the input indefinitely. No input is lost, because `in_ready`=0.

## Structure
- Shared package `logicnet_pkg` holds:
  - `N_CLASSES_MNIST`=10 and the derived `CLASS_W`
  - the state typedef `ens_argmax_state_t` {ACCUM, SCAN, HOLD}
- One sub-module, `ens_argmax_scan`: the sequential comparator holding best index and best score.
  - Inputs: start, current `acc[i]`, and i.
  - Outputs: done, best_class, best_score.
- The top level keeps the accumulator array, member counter, and FSM.

## Test plan
All scenarios use the defaults `N_ENS`=4, `N_CLASSES`=10, `LOGIT_W`=2.
- Single winner: 4 beats, class 3 = 3 and all others 0 -> `out_class`=3, `out_score`=12; `out_valid` rises 10 cycles after the 4th beat's edge.
- Tie: class 2 and class 7 each sum to 6, all others lower -> `out_class`=2, `out_score`=6.
- All-zero logits: 4 beats of zeros -> `out_class`=0, `out_score`=0.
- Back-pressure: hold `out_ready`=0 for 5 cycles in HOLD -> outputs stable and `in_ready`=0 throughout. Then send a new image with class 9 = 1 per beat -> `out_class`=9, `out_score`=4, proving the previous sums were not carried over.
- Reset mid-image: 2 beats with class 5 = 3, pulse `rst` for 1 cycle, then 4 beats with class 1 = 2 -> `out_class`=1, `out_score`=8; `out_valid`=0 during reset.
- Input bubbles: `in_valid` toggled 1,0,0,1,0,1,1 -> exactly 4 beats counted, and the result equals the gap-free case.
